fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 32, giving the PC width in bits.
REQ-002 The module SHALL have parameter INSTR_W, default 32, giving the instruction width in bits.
REQ-003 The module SHALL have parameter DEPTH, default 4, giving the number of entries; legal values are powers of two, 2 or greater.
REQ-004 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-006 The module SHALL have port flush, input, 1 bit, a synchronous discard of all entries (branch redirect).
REQ-007 The module SHALL have ports in_valid (input, 1), in_ready (output, 1), in_pc (input, ADDR_W) and in_instr (input, INSTR_W), forming the fetch-side push handshake.
REQ-008 The module SHALL have ports out_valid (output, 1), out_ready (input, 1), out_pc (output, ADDR_W) and out_instr (output, INSTR_W), forming the decode-side pop handshake.
REQ-009 The module SHALL have port step_mode, input, 1 bit; 1 selects single-step issue.
REQ-010 The module SHALL have port step_key, input, 1 bit, the step request level, already synchronised to clk.
REQ-011 The module SHALL have port count, output, $clog2(DEPTH+1) bits, giving the current occupancy.

Function
REQ-012 The module SHALL drive in_ready = (count < DEPTH) from registered state only, with no combinational path from out_ready.
REQ-013 The module SHALL perform a push when in_valid && in_ready && !flush, writing {in_pc, in_instr} at the write pointer and incrementing that pointer.
REQ-014 The module SHALL perform a pop when out_valid && out_ready && !flush, incrementing the read pointer.
REQ-015 The module SHALL wrap the read and write pointers from DEPTH-1 to 0.
REQ-016 The module SHALL update count +1 on a push only, -1 on a pop only, and leave it unchanged when a push and a pop occur in the same cycle.
REQ-017 The module SHALL have a one-cycle latency: an entry pushed into an empty queue at edge N is presented with out_valid=1 after edge N, with no same-cycle bypass.
REQ-018 When count==0, the module SHALL drive out_pc and out_instr as 0; otherwise it SHALL present the head entry.
REQ-019 The module SHALL preserve entry order exactly, with no duplicates and no drops, except on flush.
REQ-020 When flush=1 at an edge, the module SHALL clear count, both pointers and the step credit, and SHALL ignore any push or pop attempted in that cycle.
REQ-021 The module SHALL register step_key into key_q every cycle; a rising edge is step_key && !key_q.
REQ-022 The module SHALL keep a 1-bit step credit: a rising edge sets it, a pop clears it, and a pop coinciding with a rising edge leaves it set.
REQ-023 The step credit SHALL saturate at 1, so a rising edge while credit is already 1 is lost.
REQ-024 The module SHALL drive out_valid = (count != 0) && (!step_mode || credit).
REQ-025 In step mode, the module SHALL therefore issue at most one entry per step_key rising edge.
REQ-026 A step_mode change SHALL take effect combinationally and SHALL not alter the credit.
REQ-027 When full, the module SHALL accept no push even when a pop occurs in the same cycle, because in_ready is already 0.

Reset
REQ-028 While rst=1, the module SHALL hold count=0, both pointers at 0, credit=0 and key_q=0, and drive out_valid=0, in_ready=1, out_pc=0 and out_instr=0.
REQ-029 Reset assertion mid-transfer SHALL discard all entries immediately, without waiting for a clock edge.
REQ-030 Following rst deassertion, the first push SHALL be accepted at the next rising edge.
REQ-031 Storage array contents need not be reset, and SHALL never be observable while count==0.

Verification
REQ-032 With DEPTH=4 and out_ready=0, pushing PCs 0x00,0x04,0x08,0x0C,0x10 -> the bench SHALL observe in_ready=0 after the 4th push, count=4, and 0x10 not stored.
REQ-033 Draining that full queue with out_ready=1 -> the bench SHALL observe out_pc sequence 0x00,0x04,0x08,0x0C on consecutive cycles, followed by out_valid=0 and count=0.
REQ-034 With continuous push and pop at 2 entries for 10 cycles -> the bench SHALL observe count constant at 2, pointers wrapping, and order preserved.
REQ-035 With 3 entries queued, flush=1 together with in_valid=1 -> the bench SHALL observe count=0 and out_valid=0 on the next cycle, with the pushed entry discarded.
REQ-036 With step_mode=1, 3 entries queued and out_ready=1, pulsing step_key twice -> the bench SHALL observe exactly 2 pops, one per pulse, and count=1; holding step_key high SHALL give no further pops.
REQ-037 Asserting rst asynchronously mid-cycle with 2 entries queued -> the bench SHALL observe out_valid=0 and count=0 before the next edge, and in_ready=1.

Source files
------------

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue with flush and single-step issue gate
//
// Purpose: DEPTH-entry FIFO of {pc, instr} pairs between fetch and decode.
// A flush discards everything (branch redirect). In step mode, a step credit
// gates issue so that each rising edge of step_key releases one entry.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush             synchronous discard of all entries and the step credit
//   in_valid/in_ready push handshake carrying in_pc, in_instr
//   out_valid/out_ready pop handshake carrying out_pc, out_instr (0 when empty)
//   step_mode         1 = issue only on step credit
//   step_key          step request level, already synchronous to clk
//   count             current occupancy
module fetch_queue #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ADDR_W-1:0]            in_pc,
  input  logic [INSTR_W-1:0]           in_instr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ADDR_W-1:0]            out_pc,
  output logic [INSTR_W-1:0]           out_instr,
  input  logic                         step_mode,
  input  logic                         step_key,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = ADDR_W + INSTR_W;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ENT_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             credit_q, credit_d;
  logic             key_q;

  logic             push;
  logic             pop;
  logic             step_rise;
  logic [ENT_W-1:0] head;

  // Handshake outputs depend only on registered state (plus step_mode), so
  // in_ready has no path from out_ready.
  always_comb begin
    in_ready  = (count_q < FULL_CNT);
    out_valid = (count_q != '0) && (!step_mode || credit_q);
    push      = in_valid && in_ready && !flush;
    pop       = out_valid && out_ready && !flush;
    step_rise = step_key && !key_q;
    head      = mem_q[rd_ptr_q];
    // Storage is never reset, so stale contents are masked while empty.
    if (count_q == '0) begin
      out_pc    = '0;
      out_instr = '0;
    end else begin
      out_pc    = head[ENT_W-1:INSTR_W];
      out_instr = head[INSTR_W-1:0];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    credit_d = credit_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      credit_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      // Pop implies count_q != 0 and push implies count_q < DEPTH, so no wrap.
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      // A new step edge wins over the pop that consumes the previous credit;
      // the credit is a single bit, so extra edges while set are lost.
      if (step_rise) begin
        credit_d = 1'b1;
      end else if (pop) begin
        credit_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      credit_q <= 1'b0;
      key_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      credit_q <= credit_d;
      key_q    <= step_key;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_pc, in_instr};
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue with a queue-based reference model
module tb_fetch_queue;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic               clk       = 1'b0;
  logic               rst       = 1'b1;
  logic               flush     = 1'b0;
  logic               in_valid  = 1'b0;
  logic               out_ready = 1'b0;
  logic               step_mode = 1'b0;
  logic               step_key  = 1'b0;
  logic [ADDR_W-1:0]  in_pc     = '0;
  logic [INSTR_W-1:0] in_instr  = '0;
  logic               in_ready;
  logic               out_valid;
  logic [ADDR_W-1:0]  out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic [CNT_W-1:0]   count;

  int checks   = 0;
  int errors   = 0;
  int dut_pops = 0;

  // Reference model: expected contents in order, plus step credit and last key level.
  logic [63:0] sb[$];
  bit          credit_m = 1'b0;
  bit          key_m    = 1'b0;
  bit          m_rise, m_ov, m_push, m_pop;
  logic [63:0] exp_head;

  always #5 clk = ~clk;

  fetch_queue #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .step_mode(step_mode), .step_key(step_key), .count(count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] pc);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = ~pc;
    tick();
    in_valid = 1'b0;
  endtask

  // Model update: acceptance is decided from the model's own occupancy.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sb.delete();
      credit_m = 1'b0;
      key_m    = 1'b0;
    end else begin
      m_rise = step_key && !key_m;
      m_ov   = (sb.size() != 0) && (!step_mode || credit_m);
      m_push = in_valid && (sb.size() < DEPTH) && !flush;
      m_pop  = m_ov && out_ready && !flush;
      if (flush) begin
        sb.delete();
        credit_m = 1'b0;
      end else begin
        if (m_pop) void'(sb.pop_front());
        if (m_push) sb.push_back({in_pc, in_instr});
        if (m_rise) credit_m = 1'b1;
        else if (m_pop) credit_m = 1'b0;
      end
      key_m = step_key;
    end
  end

  // Monitor: compare DUT outputs against the model away from the active edge.
  always @(negedge clk) begin
    exp_head = (sb.size() != 0) ? sb[0] : 64'd0;
    check("count", 64'(count), 64'(sb.size()));
    check("in_ready", 64'(in_ready), 64'(sb.size() < DEPTH));
    check("out_valid", 64'(out_valid), 64'((sb.size() != 0) && (!step_mode || credit_m)));
    check("head", {out_pc, out_instr}, exp_head);
    if (out_valid && out_ready && !flush) dut_pops++;
  end

  int p0;

  initial begin
    // Reset state
    tick();
    check("rst_count", 64'(count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_pc", 64'(out_pc), 64'd0);
    tick();
    rst = 1'b0;

    // Fill past full: 0x10 must be refused
    for (int i = 0; i < 5; i++) push_one(32'(i * 4));
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_count", 64'(count), 64'd4);

    // Drain on consecutive cycles
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drain_valid", 64'(out_valid), 64'd1);
      check("drain_pc", 64'(out_pc), 64'(i * 4));
      tick();
    end
    @(negedge clk);
    check("drained_valid", 64'(out_valid), 64'd0);
    check("drained_count", 64'(count), 64'd0);
    tick();

    // Steady push+pop at occupancy 2 with pointer wrap
    out_ready = 1'b0;
    push_one(32'h80);
    push_one(32'h84);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_pc    = 32'h100 + 32'(i * 4);
      in_instr = 32'h5000 + 32'(i);
      @(negedge clk);
      check("steady_count", 64'(count), 64'd2);
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();

    // Flush with a simultaneous push
    out_ready = 1'b0;
    push_one(32'h200);
    push_one(32'h204);
    push_one(32'h208);
    in_valid = 1'b1;
    in_pc    = 32'hDEAD;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    repeat (2) tick();

    // Single-step: two pulses give two pops, holding the key gives none
    out_ready = 1'b0;
    step_mode = 1'b1;
    push_one(32'h300);
    push_one(32'h304);
    push_one(32'h308);
    out_ready = 1'b1;
    p0 = dut_pops;
    step_key = 1'b1; tick();
    step_key = 1'b0; tick();
    step_key = 1'b1; tick();
    repeat (6) tick();
    check("step_pops", 64'(dut_pops - p0), 64'd2);
    check("step_count", 64'(count), 64'd1);
    step_key  = 1'b0;
    step_mode = 1'b0;
    repeat (2) tick();

    // Asynchronous reset mid-cycle
    out_ready = 1'b0;
    push_one(32'h400);
    push_one(32'h404);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    tick();
    rst = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      if (c % 64 == 0) step_mode = 1'($urandom_range(0, 1));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_pc     = $urandom;
      in_instr  = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      step_key  = ($urandom_range(0, 3) == 0);
      tick();
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
